rx_in_arrange: RTL and testbench

- Receive-side counterpart of the transmit output arranger. Takes the baseband sample stream (1x or 2x rate) after frame timing sync and decimates it to 20 MSa/s.
- Strips the short-training field and every guard interval or cyclic prefix.
- Emits the two long-training symbols, the SIGNAL symbol and N DATA symbols as tagged 64-sample bursts to channel estimation and the FFT.
- An internal FIFO absorbs samples while the SIGNAL decoder resolves the DATA symbol count.

---
 rtl/rx_in_arrange_if.sv | 33 +++
 rtl/rx_in_arrange.sv | 179 +++++++++++++++++
 tb/tb_rx_in_arrange.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_in_arrange_if.sv
// Sample-stream and control bundle between frame sync and the receive arranger.
interface rx_in_arrange_if;
  logic [1:0]  rx_Downsample;
  logic        rx_frame_start;
  logic        rx_frame_abort;
  logic        rx_in_valid;
  logic [15:0] rx_in_re;
  logic [15:0] rx_in_im;
  logic        rx_sym_num_valid;
  logic [11:0] rx_sym_num;
  logic        rx_ltf_valid;
  logic        rx_sig_valid;
  logic        rx_data_valid;
  logic        rx_data_sym_last;
  logic [15:0] rx_out_re;
  logic [15:0] rx_out_im;
  logic        rx_busy;
  logic        rx_overflow;

  modport master (
    output rx_Downsample, rx_frame_start, rx_frame_abort, rx_in_valid, rx_in_re, rx_in_im,
           rx_sym_num_valid, rx_sym_num,
    input  rx_ltf_valid, rx_sig_valid, rx_data_valid, rx_data_sym_last, rx_out_re, rx_out_im,
           rx_busy, rx_overflow
  );

  modport slave (
    input  rx_Downsample, rx_frame_start, rx_frame_abort, rx_in_valid, rx_in_re, rx_in_im,
           rx_sym_num_valid, rx_sym_num,
    output rx_ltf_valid, rx_sig_valid, rx_data_valid, rx_data_sym_last, rx_out_re, rx_out_im,
           rx_busy, rx_overflow
  );
endinterface

// File: rtl/rx_in_arrange.sv
// Receive arranger: decimates to 20 MSa/s, strips STF and guard intervals, and emits
// tagged 64-sample LTF/SIGNAL/DATA bursts; a FIFO covers the SIGNAL decode latency.
module rx_in_arrange #(
  parameter int FIFO_DEPTH = 1024,
  parameter int STS_LEN    = 160,
  parameter int LTS_GI_LEN = 32,
  parameter int LTS_LEN    = 128,
  parameter int CP_LEN     = 16,
  parameter int SYM_LEN    = 64
) (
  input  logic           clk_Modulation,
  input  logic           reset,
  rx_in_arrange_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STS_LEN + 1);
  localparam int CW = $clog2(LTS_GI_LEN + LTS_LEN + CP_LEN + SYM_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LTS_GI, S_LTS, S_SIG_CP, S_SIG, S_WAIT_LEN, S_DAT_CP, S_DAT
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_len;
  logic [11:0]   r_sym_rem;
  logic [1:0]    r_mode, w_mode;
  logic          r_phase, w_phase;
  logic [SW-1:0] r_sts_cnt;
  logic          r_busy, r_ovf;
  logic [AW:0]   r_wptr, r_rptr, w_level;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [31:0]   w_rdata;
  logic          w_accept, w_active, w_kept, w_wr, w_full, w_empty;
  logic          w_pop, w_seg_end, w_flush;
  logic          w_tag_ltf, w_tag_sig, w_tag_dat, w_last;
  logic          r_ltf, r_sig, r_dat, r_last;
  logic [15:0]   r_re, r_im;

  assign w_accept = bus.rx_frame_start && !bus.rx_frame_abort && (r_state == S_IDLE) && !r_busy &&
                    ((bus.rx_Downsample == 2'd1) || (bus.rx_Downsample == 2'd2));
  // The start-pulse sample already uses the new mode and a cleared phase.
  assign w_mode   = w_accept ? bus.rx_Downsample : r_mode;
  assign w_phase  = w_accept ? 1'b0 : r_phase;
  assign w_active = w_accept || (r_state != S_IDLE);
  assign w_kept   = bus.rx_in_valid && w_active && ((w_mode == 2'd2) || w_phase);
  assign w_wr     = w_kept && (r_sts_cnt == SW'(STS_LEN)) && (r_state != S_IDLE);
  assign w_level  = r_wptr - r_rptr;
  assign w_full   = w_level[AW];
  assign w_empty  = (r_wptr == r_rptr);
  assign w_rdata  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_Modulation or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_len     = '0;
    w_pop     = 1'b0;
    w_seg_end = 1'b0;
    w_tag_ltf = 1'b0;
    w_tag_sig = 1'b0;
    w_tag_dat = 1'b0;
    w_last    = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      S_IDLE:             if (w_accept) w_next = S_LTS_GI;
      S_LTS_GI:           w_len = CW'(LTS_GI_LEN);
      S_LTS:              w_len = CW'(LTS_LEN);
      S_SIG_CP, S_DAT_CP: w_len = CW'(CP_LEN);
      S_SIG, S_DAT:       w_len = CW'(SYM_LEN);
      S_WAIT_LEN:
        if (bus.rx_sym_num_valid) w_next = (bus.rx_sym_num == 12'd0) ? S_IDLE : S_DAT_CP;
      default: ;
    endcase
    w_pop     = (w_len != '0) && !w_empty;
    w_seg_end = w_pop && (r_cnt == w_len - 1'b1);
    w_tag_ltf = w_pop && (r_state == S_LTS);
    w_tag_sig = w_pop && (r_state == S_SIG);
    w_tag_dat = w_pop && (r_state == S_DAT);
    w_last    = w_seg_end && (r_state == S_DAT) && (r_sym_rem == 12'd1);
    if (w_seg_end) begin
      case (r_state)
        S_LTS_GI: w_next = S_LTS;
        S_LTS:    w_next = S_SIG_CP;
        S_SIG_CP: w_next = S_SIG;
        S_SIG:    w_next = S_WAIT_LEN;
        S_DAT_CP: w_next = S_DAT;
        S_DAT:    w_next = (r_sym_rem == 12'd1) ? S_IDLE : S_DAT_CP;
        default: ;
      endcase
    end
    if (bus.rx_frame_abort) begin
      w_next    = S_IDLE;
      w_pop     = 1'b0;
      w_seg_end = 1'b0;
      w_tag_ltf = 1'b0;
      w_tag_sig = 1'b0;
      w_tag_dat = 1'b0;
      w_last    = 1'b0;
    end
    w_flush = bus.rx_frame_abort || ((r_state != S_IDLE) && (w_next == S_IDLE));
  end

  always_ff @(posedge clk_Modulation or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_sym_rem <= '0;
      r_mode    <= '0;
      r_phase   <= 1'b0;
      r_sts_cnt <= '0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_seg_end || bus.rx_frame_abort) r_cnt <= '0;
      else if (w_pop)                      r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_WAIT_LEN) && bus.rx_sym_num_valid && !bus.rx_frame_abort)
        r_sym_rem <= bus.rx_sym_num;
      else if (w_seg_end && (r_state == S_DAT))
        r_sym_rem <= r_sym_rem - 1'b1;
      if (w_accept) r_mode <= bus.rx_Downsample;
      if (bus.rx_in_valid && w_active) r_phase <= !w_phase;
      if (w_accept)
        r_sts_cnt <= w_kept ? SW'(1) : '0;
      else if (w_kept && (r_sts_cnt != SW'(STS_LEN)))
        r_sts_cnt <= r_sts_cnt + 1'b1;
      // Normal end holds busy one extra cycle so it covers the last registered sample.
      if (bus.rx_frame_abort)    r_busy <= 1'b0;
      else if (w_accept)         r_busy <= 1'b1;
      else if (r_state == S_IDLE) r_busy <= 1'b0;
      if (w_accept)                                         r_ovf <= 1'b0;
      else if (w_wr && w_full && !bus.rx_frame_abort)       r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_Modulation or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr && !w_full) r_wptr <= r_wptr + 1'b1;
      if (w_pop)           r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_Modulation) begin
    if (w_wr && !w_full && !w_flush) r_mem[r_wptr[AW-1:0]] <= {bus.rx_in_im, bus.rx_in_re};
  end

  always_ff @(posedge clk_Modulation or negedge reset) begin
    if (!reset) begin
      r_ltf  <= 1'b0;
      r_sig  <= 1'b0;
      r_dat  <= 1'b0;
      r_last <= 1'b0;
      r_re   <= '0;
      r_im   <= '0;
    end else begin
      r_ltf  <= w_tag_ltf;
      r_sig  <= w_tag_sig;
      r_dat  <= w_tag_dat;
      r_last <= w_last;
      if (w_tag_ltf || w_tag_sig || w_tag_dat) {r_im, r_re} <= w_rdata;
    end
  end

  assign bus.rx_ltf_valid     = r_ltf;
  assign bus.rx_sig_valid     = r_sig;
  assign bus.rx_data_valid    = r_dat;
  assign bus.rx_data_sym_last = r_last;
  assign bus.rx_out_re        = r_re;
  assign bus.rx_out_im        = r_im;
  assign bus.rx_busy          = r_busy;
  assign bus.rx_overflow      = r_ovf;
endmodule

// File: tb/tb_rx_in_arrange.sv
// Bench for rx_in_arrange: queue-based reference model compared every cycle, plus
// literal expectations for the ramp, decimation, zero-length, overflow, abort and reset cases.
module tb_rx_in_arrange;
  localparam int DEPTH = 1024;
  localparam int STS   = 160;
  localparam int PRE   = 240;   // pops before the symbol count is needed: 32+128+16+64
  localparam int DSYM  = 80;    // pops per DATA symbol: 16 CP + 64
  localparam int BOUND = 6000;

  logic clk;
  logic rst_n;
  rx_in_arrange_if bus();

  rx_in_arrange dut (.clk_Modulation(clk), .reset(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;

  // ---------------- reference model ----------------
  bit          m_act, m_busy, m_ovf, m_known, m_phase;
  bit          m_ltf, m_sig, m_dat, m_last;
  logic [1:0]  m_mode;
  int          m_sts, m_np, m_nsym;
  logic [15:0] m_re, m_im;
  logic [31:0] mq[$];

  // Classify the n-th FIFO pop of a frame: 0 discard, 1 ltf, 2 sig, 3 data.
  function automatic int pop_cls(input int n);
    if (n < 32)  return 0;
    if (n < 160) return 1;
    if (n < 176) return 0;
    if (n < PRE) return 2;
    return (((n - PRE) % DSYM) < 16) ? 0 : 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc, kept, endf;
    int pre, c;
    logic [31:0] v;
    if (!rst_n) begin
      m_act = 0; m_busy = 0; m_ovf = 0; m_known = 0; m_phase = 0;
      m_ltf = 0; m_sig = 0; m_dat = 0; m_last = 0;
      m_mode = 0; m_sts = 0; m_np = 0; m_nsym = 0; m_re = 0; m_im = 0;
      mq.delete();
    end else begin
      m_ltf = 0; m_sig = 0; m_dat = 0; m_last = 0;
      if (bus.rx_frame_abort) begin
        m_act = 0; m_busy = 0; mq.delete();
      end else begin
        acc = bus.rx_frame_start && !m_act && !m_busy &&
              (bus.rx_Downsample == 2'd1 || bus.rx_Downsample == 2'd2);
        if (!m_act && m_busy) m_busy = 0;
        if (acc) begin
          m_mode = bus.rx_Downsample; m_phase = 0; m_ovf = 0; m_busy = 1; m_sts = 0;
        end
        kept = 0;
        if (bus.rx_in_valid && (acc || m_act)) begin
          kept = (m_mode == 2'd2) || m_phase;
          m_phase = !m_phase;
        end
        pre = mq.size();
        endf = 0;
        if (m_act) begin
          if (pre > 0 && (m_np < PRE || (m_known && m_np < PRE + DSYM * m_nsym))) begin
            v = mq.pop_front();
            c = pop_cls(m_np);
            m_ltf = (c == 1); m_sig = (c == 2); m_dat = (c == 3);
            if (c != 0) {m_im, m_re} = v;
            if (m_known && m_np == PRE + DSYM * m_nsym - 1) begin
              m_last = 1; endf = 1;
            end
            m_np++;
          end else if (m_np == PRE && !m_known && bus.rx_sym_num_valid) begin
            m_known = 1;
            m_nsym  = int'(bus.rx_sym_num);
            if (m_nsym == 0) endf = 1;
          end
        end
        if (kept) begin
          if (m_sts < STS) m_sts++;
          else if (m_act) begin
            if (pre < DEPTH) mq.push_back({bus.rx_in_im, bus.rx_in_re});
            else m_ovf = 1;
          end
        end
        if (acc)  begin m_act = 1; m_np = 0; m_known = 0; end
        if (endf) begin m_act = 0; mq.delete(); end
      end
    end
  end

  // ---------------- per-cycle compare and observation ----------------
  int ltf_obs[$], sig_obs[$], dat_obs[$];
  int last_n, last_v, dead_seen;

  always @(negedge clk) begin
    vectors++;
    if (bus.rx_ltf_valid !== m_ltf || bus.rx_sig_valid !== m_sig || bus.rx_data_valid !== m_dat ||
        bus.rx_data_sym_last !== m_last || bus.rx_out_re !== m_re || bus.rx_out_im !== m_im ||
        bus.rx_busy !== m_busy || bus.rx_overflow !== m_ovf) begin
      miscompares++;
      if (nprint < 10)
        $display("FAIL cycle t=%0t got tags=%b%b%b last=%b re=%h im=%h busy=%b ovf=%b, want tags=%b%b%b last=%b re=%h im=%h busy=%b ovf=%b",
                 $time, bus.rx_ltf_valid, bus.rx_sig_valid, bus.rx_data_valid, bus.rx_data_sym_last,
                 bus.rx_out_re, bus.rx_out_im, bus.rx_busy, bus.rx_overflow,
                 m_ltf, m_sig, m_dat, m_last, m_re, m_im, m_busy, m_ovf);
      nprint++;
    end
    if (bus.rx_ltf_valid)  ltf_obs.push_back(int'(bus.rx_out_re));
    if (bus.rx_sig_valid)  sig_obs.push_back(int'(bus.rx_out_re));
    if (bus.rx_data_valid) dat_obs.push_back(int'(bus.rx_out_re));
    if (bus.rx_data_sym_last) begin last_n++; last_v = int'(bus.rx_out_re); end
    if ((bus.rx_ltf_valid || bus.rx_sig_valid || bus.rx_data_valid) &&
        (bus.rx_out_re == 16'hDEAD || bus.rx_out_im == 16'hDEAD)) dead_seen++;
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  // ---------------- stimulus ----------------
  int k = 0;
  int pat = 0;     // 0 ramp, 1 ramp with even-index samples 0xDEAD, 2 random
  bit gaps = 0;
  int ovf_after_start;
  bit aborted;

  task automatic step();
    bit v;
    if (bus.rx_frame_start) k = 0;
    v = bus.rx_frame_start || !gaps || ($urandom_range(0, 3) != 0);
    bus.rx_in_valid = v;
    if (v) begin
      case (pat)
        0: begin bus.rx_in_re = 16'(k); bus.rx_in_im = 16'(k) ^ 16'h8000; end
        1: begin
          bus.rx_in_re = k[0] ? 16'(k) : 16'hDEAD;
          bus.rx_in_im = k[0] ? 16'(k) : 16'hDEAD;
        end
        default: begin bus.rx_in_re = 16'($urandom); bus.rx_in_im = 16'($urandom); end
      endcase
      k++;
    end else begin
      bus.rx_in_re = 16'($urandom);
      bus.rx_in_im = 16'($urandom);
    end
    @(posedge clk);
    #1;
    bus.rx_frame_start   = 1'b0;
    bus.rx_frame_abort   = 1'b0;
    bus.rx_sym_num_valid = 1'b0;
  endtask

  task automatic clear_obs();
    ltf_obs.delete(); sig_obs.delete(); dat_obs.delete();
    last_n = 0; last_v = -1; dead_seen = 0;
  endtask

  task automatic run_frame(input int mode, input int p, input bit g, input int nsym,
                           input int wait_cyc, input int ab_sym, input bit stray);
    int n;
    pat = p; gaps = g; aborted = 0;
    clear_obs();
    bus.rx_Downsample  = 2'(mode);
    bus.rx_frame_start = 1'b1;
    step();
    ovf_after_start = int'(bus.rx_overflow);
    if (stray) begin
      repeat (3) step();
      bus.rx_frame_start = 1'b1; bus.rx_sym_num = 12'd5; bus.rx_sym_num_valid = 1'b1;
      step();
    end
    n = 0;
    while (sig_obs.size() < 64 && n < BOUND) begin step(); n++; end
    chk("sig_burst_seen", sig_obs.size(), 64);
    repeat (wait_cyc) step();
    bus.rx_sym_num = 12'(nsym); bus.rx_sym_num_valid = 1'b1;
    step();
    n = 0;
    while (bus.rx_busy && n < BOUND) begin
      if (ab_sym >= 0 && !aborted && dat_obs.size() >= 64 * ab_sym + 20) begin
        bus.rx_frame_abort = 1'b1;
        step();
        chk("abort_tags", int'({bus.rx_ltf_valid, bus.rx_sig_valid, bus.rx_data_valid}), 0);
        chk("abort_busy", int'(bus.rx_busy), 0);
        aborted = 1;
      end else begin
        step(); n++;
      end
    end
    chk("frame_end_busy", int'(bus.rx_busy), 0);
    repeat (5) step();
  endtask

  task automatic chk_ramp_n2(input string t);
    chk({t, "_ltf_n"},  ltf_obs.size(), 128);
    chk({t, "_ltf0"},   qat(ltf_obs, 0), 192);
    chk({t, "_ltf127"}, qat(ltf_obs, 127), 319);
    chk({t, "_sig_n"},  sig_obs.size(), 64);
    chk({t, "_sig0"},   qat(sig_obs, 0), 336);
    chk({t, "_sig63"},  qat(sig_obs, 63), 399);
    chk({t, "_dat_n"},  dat_obs.size(), 128);
    chk({t, "_dat0"},   qat(dat_obs, 0), 416);
    chk({t, "_dat63"},  qat(dat_obs, 63), 479);
    chk({t, "_dat64"},  qat(dat_obs, 64), 496);
    chk({t, "_dat127"}, qat(dat_obs, 127), 559);
    chk({t, "_last_n"}, last_n, 1);
    chk({t, "_last_v"}, last_v, 559);
  endtask

  task automatic chk_outputs_zero(input string t);
    chk({t, "_tags"}, int'({bus.rx_ltf_valid, bus.rx_sig_valid, bus.rx_data_valid, bus.rx_data_sym_last}), 0);
    chk({t, "_re"},   int'(bus.rx_out_re), 0);
    chk({t, "_im"},   int'(bus.rx_out_im), 0);
    chk({t, "_busy"}, int'(bus.rx_busy), 0);
    chk({t, "_ovf"},  int'(bus.rx_overflow), 0);
  endtask

  initial begin
    int n, nr;
    rst_n = 1'b0;
    bus.rx_Downsample = 2'd2; bus.rx_frame_start = 1'b0; bus.rx_frame_abort = 1'b0;
    bus.rx_in_valid = 1'b0; bus.rx_in_re = '0; bus.rx_in_im = '0;
    bus.rx_sym_num_valid = 1'b0; bus.rx_sym_num = '0;
    clear_obs();
    repeat (3) step();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // 1x ramp, two DATA symbols, count given 10 cycles after SIG
    run_frame(2, 0, 0, 2, 10, -1, 0);
    chk_ramp_n2("ramp");

    // 2x stream: only even-numbered samples (odd 0-based index) survive decimation
    run_frame(1, 1, 1, int'($urandom_range(1, 3)), 5, -1, 0);
    chk("dec_ltf0", qat(ltf_obs, 0), 385);
    chk("dec_ltf_n", ltf_obs.size(), 128);
    chk("dec_no_dead", dead_seen, 0);

    // zero DATA symbols, twice
    run_frame(2, 0, 0, 0, 3, -1, 0);
    chk("n0a_sig0", qat(sig_obs, 0), 336);
    chk("n0a_dat_n", dat_obs.size(), 0);
    run_frame(2, 0, 0, 0, 3, -1, 0);
    chk("n0b_ltf0", qat(ltf_obs, 0), 192);
    chk("n0b_sig63", qat(sig_obs, 63), 399);
    chk("n0b_dat_n", dat_obs.size(), 0);
    chk("n0b_last_n", last_n, 0);

    // withheld count overflows the FIFO; frame still completes
    run_frame(2, 0, 0, 1, 1100, -1, 0);
    chk("ovf_flag", int'(bus.rx_overflow), 1);
    chk("ovf_dat_n", dat_obs.size(), 64);
    chk("ovf_last_n", last_n, 1);

    // abort during DATA symbol 1 of 3, then a clean frame
    run_frame(2, 0, 0, 3, 2, 1, 0);
    chk("ovf_cleared_at_start", ovf_after_start, 0);
    chk("abort_seen", int'(aborted), 1);
    chk("abort_last_n", last_n, 0);
    run_frame(2, 0, 0, 2, 10, -1, 0);
    chk_ramp_n2("post_abort");

    // reset mid-LTS
    pat = 0; gaps = 0; clear_obs();
    bus.rx_Downsample = 2'd2; bus.rx_frame_start = 1'b1;
    step();
    n = 0;
    while (ltf_obs.size() < 50 && n < BOUND) begin step(); n++; end
    chk("mid_lts_reached", int'(ltf_obs.size() >= 50), 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    step();
    rst_n = 1'b1;
    step();
    run_frame(2, 0, 0, 2, 10, -1, 0);
    chk_ramp_n2("post_reset");

    // invalid decimation modes are ignored
    bus.rx_Downsample = 2'd3; bus.rx_frame_start = 1'b1;
    step();
    chk("mode3_busy", int'(bus.rx_busy), 0);
    bus.rx_Downsample = 2'd0; bus.rx_frame_start = 1'b1;
    step();
    repeat (20) step();
    chk("mode0_busy", int'(bus.rx_busy), 0);

    // randomized frames with gaps, stray start and stray count
    for (int i = 0; i < 4; i++) begin
      nr = int'($urandom_range(1, 3));
      run_frame(int'($urandom_range(1, 2)), 2, 1, nr, int'($urandom_range(0, 30)), -1, 1);
      chk("rnd_dat_n", dat_obs.size(), 64 * nr);
      chk("rnd_last_n", last_n, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
